dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MIPS core: the slave end of the core's data-memory port
//  (ALUresult as address, WriteDataMem, MemWrite/MemRead, ReadDataMem).
//  Adds programmable wait states and a ready/stall handshake, so the core can be run
//  against slower memory. Holds a word-addressed RAM array. Sits between TOP_level's datapath and the data RAM.
// PARAMETERS
//  ADDR_WIDTH   8            word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//  WAIT_STATES  2            extra cycles between request capture and access (0..15)
//  ERR_DATA     32'hDEADBEEF ReadDataMem value returned on a bus error
// PORTS
//  CLK          in   1   clock, all state updates on posedge
//  reset        in   1   synchronous, active-low reset
//  MemRead      in   1   read request; held high until MemReady
//  MemWrite     in   1   write request; held high until MemReady
//  ALUresult    in   32  byte address from core ALU
//  WriteDataMem in   32  write data
//  ReadDataMem  out  32  registered read data, valid when MemReady=1
//  MemReady     out  1   registered, 1-cycle pulse: transaction complete
//  MemStall     out  1   combinational: core must hold PC/pipeline this cycle
//  BusError     out  1   registered, pulses with MemReady on a faulted transaction
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, wait counter=0, ReadDataMem=0, MemReady=0,
//    BusError=0. RAM contents untouched. Reset mid-transaction aborts it; a pending write is NOT performed.
//  - FSM states IDLE, WAIT, ACCESS.
//    IDLE:   req = MemRead|MemWrite. If req: capture addr, wdata, op; cnt<=WAIT_STATES-1;
//            next = WAIT (WAIT_STATES>0) else ACCESS. If no req: stay.
//    WAIT:   cnt decrements each cycle; when cnt==0 next = ACCESS.
//    ACCESS: MemReady=1 for exactly this cycle. The write commits to RAM on the posedge that enters ACCESS.
//            For a read, ReadDataMem is loaded on that same edge. next = IDLE unconditionally.
//  - Latency: MemReady rises WAIT_STATES+1 cycles after the capturing edge. Back-to-back requests need
//    one IDLE cycle between them: a request still held in the IDLE cycle after ACCESS starts a new transaction.
//  - MemStall = (state==IDLE & req) | (state==WAIT). MemStall is 0 in ACCESS, so the core advances on the
//    edge ending ACCESS.
//  - Address: word index = addr[ADDR_WIDTH+1:2].
//  - Fault conditions: addr[1:0]!=0, or addr[31:ADDR_WIDTH+2]!=0, or MemRead&MemWrite at capture.
//    On a fault: full wait sequence still runs; no RAM write occurs; in ACCESS, BusError=1 and ReadDataMem=ERR_DATA.
//  - Inputs are sampled only at the capture edge. Changes to ALUresult/WriteDataMem/req during WAIT are ignored.
//    Dropping req during WAIT does not cancel the transaction.
//  - ReadDataMem holds its last value outside ACCESS. A write leaves ReadDataMem unchanged.
//  - RAM has no reset and is initialised to 0 by the bench only.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with MemWrite=1 -> MemReady=0, BusError=0, ReadDataMem=0, no RAM write.
//  2 Write then read, WAIT_STATES=2: write 0x12345678 @0x10 -> MemReady 3 cycles after capture.
//    Then read @0x10 -> ReadDataMem=0x12345678, MemStall high 3 cycles.
//  3 WAIT_STATES=0: read @0x04 -> MemReady on the cycle right after capture, MemStall high 1 cycle.
//  4 Misaligned write 0xAAAAAAAA @0x11 -> BusError=1 with MemReady; a read @0x10 still returns 0x12345678.
//  5 Out of range (ADDR_WIDTH=8) read @0x400 -> BusError=1, ReadDataMem=0xDEADBEEF.
//    MemRead&MemWrite together @0x0 -> BusError=1, RAM[0] unchanged.
//  6 Reset mid-op: start a write 0x55 @0x20, assert reset in WAIT -> state IDLE, RAM[8] still 0.
//    Next read @0x20 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states and ready/stall handshake
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUresult,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] ReadDataMem,
  output logic        MemReady,
  output logic        MemStall,
  output logic        BusError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic                    r_rd;
  logic                    r_wr;
  logic                    r_fault;
  logic [31:0]             r_rdata;
  logic                    r_ready;
  logic                    r_err;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_req;
  logic                    w_fault_in;
  logic                    w_from_idle;
  logic                    w_enter_access;
  logic [ADDR_WIDTH-1:0]   w_acc_idx;
  logic [31:0]             w_acc_wdata;
  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic                    w_acc_fault;
  logic                    w_do_write;

  assign w_req      = MemRead | MemWrite;
  assign w_fault_in = (ALUresult[1:0] != 2'b00)
                    | (ALUresult[31:ADDR_WIDTH+2] != '0)
                    | (MemRead & MemWrite);

  // With zero wait states the access happens on the capture edge itself,
  // so the access operands come straight from the inputs instead of the capture registers.
  assign w_from_idle    = (r_state == S_IDLE);
  assign w_enter_access = (w_from_idle && w_req && (WAIT_STATES == 0))
                        || ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_acc_idx      = w_from_idle ? ALUresult[ADDR_WIDTH+1:2] : r_idx;
  assign w_acc_wdata    = w_from_idle ? WriteDataMem : r_wdata;
  assign w_acc_rd       = w_from_idle ? MemRead : r_rd;
  assign w_acc_wr       = w_from_idle ? MemWrite : r_wr;
  assign w_acc_fault    = w_from_idle ? w_fault_in : r_fault;
  assign w_do_write     = w_enter_access & w_acc_wr & ~w_acc_fault;

  always_ff @(posedge CLK) begin
    if (reset && w_do_write) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= ALUresult[ADDR_WIDTH+1:2];
            r_wdata <= WriteDataMem;
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_fault <= w_fault_in;
            r_cnt   <= 4'(WAIT_STATES - 1);
            r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
      if (w_enter_access) begin
        r_ready <= 1'b1;
        r_err   <= w_acc_fault;
        if (w_acc_fault) begin
          r_rdata <= ERR_DATA;
        end else if (w_acc_rd) begin
          r_rdata <= r_mem[w_acc_idx];
        end
      end
    end
  end

  assign ReadDataMem = r_rdata;
  assign MemReady    = r_ready;
  assign BusError    = r_err;
  assign MemStall    = (w_from_idle & w_req) | (r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (2 and 0 wait-state instances)
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_stall, a_err, b_ready, b_stall, b_err;

  int checks;
  int failures;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2), .ERR_DATA(32'hDEADBEEF)) u_dut_a (
    .CLK(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
    .ALUresult(a_addr), .WriteDataMem(a_wdata), .ReadDataMem(a_rdata),
    .MemReady(a_ready), .MemStall(a_stall), .BusError(a_err)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0), .ERR_DATA(32'hDEADBEEF)) u_dut_b (
    .CLK(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
    .ALUresult(b_addr), .WriteDataMem(b_wdata), .ReadDataMem(b_rdata),
    .MemReady(b_ready), .MemStall(b_stall), .BusError(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one request on the selected instance; lat counts edges from capture to MemReady.
  task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                     output int lat, output int stalls);
    bit done;
    @(negedge clk);
    if (sel) begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; end
    else     begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; end
    #1;
    lat = 0; stalls = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? b_stall : a_stall) stalls++;
      @(posedge clk); #1;
      lat++;
      if (sel ? b_ready : a_ready) begin done = 1'b1; break; end
    end
    rdata = sel ? b_rdata : a_rdata;
    err   = sel ? b_err : a_err;
    if (sel) begin b_rd = 1'b0; b_wr = 1'b0; end
    else     begin a_rd = 1'b0; a_wr = 1'b0; end
    chk("txn_completes", {31'd0, done}, 32'd1);
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        e;
  int          l, s, pulses;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    txn(0, 0, 1, 32'h0,  32'h0, rd, e, l, s);
    txn(0, 0, 1, 32'h10, 32'h0, rd, e, l, s);
    txn(0, 0, 1, 32'h20, 32'h0, rd, e, l, s);
    txn(1, 0, 1, 32'h04, 32'h0, rd, e, l, s);

    // reset held with a write request pending
    @(negedge clk);
    reset = 1'b0; a_wr = 1'b1; a_addr = 32'h0; a_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_err",   {31'd0, a_err},   32'd0);
    chk("rst_rdata", a_rdata,          32'd0);
    @(negedge clk);
    a_wr = 1'b0; reset = 1'b1;
    @(posedge clk);
    txn(0, 1, 0, 32'h0, 32'h0, rd, e, l, s);
    chk("rst_no_write", rd, 32'd0);

    txn(0, 0, 1, 32'h10, 32'h12345678, rd, e, l, s);
    chk("wr_lat",         l,  32'd3);
    chk("wr_err",         {31'd0, e}, 32'd0);
    chk("wr_keeps_rdata", rd, 32'd0);
    txn(0, 1, 0, 32'h10, 32'h0, rd, e, l, s);
    chk("rd_data",  rd, 32'h12345678);
    chk("rd_lat",   l,  32'd3);
    chk("rd_stall", s,  32'd3);

    txn(1, 0, 1, 32'h04, 32'hCAFEF00D, rd, e, l, s);
    chk("ws0_wr_lat", l, 32'd1);
    txn(1, 1, 0, 32'h04, 32'h0, rd, e, l, s);
    chk("ws0_rd_data",  rd, 32'hCAFEF00D);
    chk("ws0_rd_lat",   l,  32'd1);
    chk("ws0_rd_stall", s,  32'd1);

    txn(0, 0, 1, 32'h11, 32'hAAAAAAAA, rd, e, l, s);
    chk("misal_err",   {31'd0, e}, 32'd1);
    chk("misal_lat",   l,  32'd3);
    chk("misal_rdata", rd, 32'hDEADBEEF);
    txn(0, 1, 0, 32'h10, 32'h0, rd, e, l, s);
    chk("misal_nowr", rd, 32'h12345678);
    chk("misal_rd_err", {31'd0, e}, 32'd0);

    txn(0, 1, 0, 32'h400, 32'h0, rd, e, l, s);
    chk("oor_err",   {31'd0, e}, 32'd1);
    chk("oor_rdata", rd, 32'hDEADBEEF);
    txn(0, 1, 1, 32'h0, 32'h77777777, rd, e, l, s);
    chk("rdwr_err", {31'd0, e}, 32'd1);
    txn(0, 1, 0, 32'h0, 32'h0, rd, e, l, s);
    chk("rdwr_nowr", rd, 32'd0);

    txn(0, 1, 0, 32'h10, 32'h0, rd, e, l, s);
    chk("pre_rst_rdata", rd, 32'h12345678);

    // reset while the write is in WAIT
    @(negedge clk);
    a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", {31'd0, a_ready}, 32'd0);
    chk("midrst_rdata", a_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1; a_wr = 1'b0;
    #1;
    chk("midrst_idle", {31'd0, a_stall}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    chk("midrst_no_ready", pulses, 32'd0);
    txn(0, 1, 0, 32'h20, 32'h0, rd, e, l, s);
    chk("midrst_nowr", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
